enc_quad_frontend: RTL and testbench

- Upstream conditioning stage for the encoder speed circuit.
- Takes raw quadrature channels A/B from the motor encoder pins and synchronises and glitch-filters them.
- Decodes them 4x into single-cycle step pulses with direction.
- Regenerates the square-wave `ticks` signal that the downstream rpm-measurement stage consumes, so that stage only ever sees clean, clock-aligned edges.

---
 rtl/enc_pkg.sv | 29 ++
 rtl/enc_quad_frontend_if.sv | 22 ++
 rtl/enc_chan_filter.sv | 46 ++++
 rtl/enc_quad_frontend.sv | 134 +++++++++++++
 tb/tb_enc_quad_frontend.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared types and constants for the encoder quadrature front end
package enc_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } enc_state_t;

    localparam int DEF_FILT_CYCLES = 16;
    localparam int DEF_TICK_DIV    = 2;

    // Quadrature states as {a,b}, listed in forward (A leads B) order
    localparam logic [1:0] QD_S0 = 2'b00;
    localparam logic [1:0] QD_S1 = 2'b10;
    localparam logic [1:0] QD_S2 = 2'b11;
    localparam logic [1:0] QD_S3 = 2'b01;

    function automatic logic [1:0] fwd_next(input logic [1:0] s);
        logic [1:0] n;
        case (s)
            QD_S0:   n = QD_S1;
            QD_S1:   n = QD_S2;
            QD_S2:   n = QD_S3;
            default: n = QD_S0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/enc_quad_frontend_if.sv
// rtl/enc_quad_frontend_if.sv - encoder pins in, conditioned step/dir/ticks/pos out
interface enc_quad_frontend_if #(
    parameter int POS_W = 16
);
    logic                    enc_a;
    logic                    enc_b;
    logic                    ticks;
    logic                    step;
    logic                    dir;
    logic                    err;
    logic signed [POS_W-1:0] pos;

    modport master (
        input  enc_a, enc_b,
        output ticks, step, dir, err, pos
    );

    modport slave (
        output enc_a, enc_b,
        input  ticks, step, dir, err, pos
    );
endinterface

// File: rtl/enc_chan_filter.sv
// rtl/enc_chan_filter.sv - two-flop synchroniser plus stability glitch filter for one channel
module enc_chan_filter
    import enc_pkg::*;
#(
    parameter int FILT_CYCLES = DEF_FILT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic filt,
    output logic filt_nxt
);
    localparam int CW = $clog2(FILT_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        filt_nxt = filt;
        cnt_nxt  = '0;
        if (s2 != filt) begin
            if (cnt == CW'(FILT_CYCLES - 1)) begin
                filt_nxt = s2;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            filt <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            cnt  <= cnt_nxt;
            filt <= filt_nxt;
        end
    end

endmodule

// File: rtl/enc_quad_frontend.sv
// rtl/enc_quad_frontend.sv - quadrature conditioning, 4x decode and ticks regeneration; ENC_POS_COUNT_EN adds pos counter
module enc_quad_frontend
    import enc_pkg::*;
#(
    parameter int FILT_CYCLES = DEF_FILT_CYCLES,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int POS_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    enc_quad_frontend_if.master bus
);
    localparam int IW = $clog2(FILT_CYCLES + 3);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic          a_f, a_nxt, b_f, b_nxt;
    enc_state_t    state, state_nxt;
    logic [IW-1:0] init_cnt;
    logic [1:0]    prev;
    logic [1:0]    cur;
    logic          step_nxt, err_nxt, fwd, load_init;
    logic          step_q, err_q, dir_q, ticks_q;
    logic [DW-1:0] div_cnt;

    enc_chan_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_a (
        .clk      (clk),
        .rst      (rst),
        .din      (bus.enc_a),
        .filt     (a_f),
        .filt_nxt (a_nxt)
    );

    enc_chan_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_b (
        .clk      (clk),
        .rst      (rst),
        .din      (bus.enc_b),
        .filt     (b_f),
        .filt_nxt (b_nxt)
    );

    assign cur = {a_f, b_f};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = 1'b0;
        err_nxt   = 1'b0;
        fwd       = 1'b0;
        load_init = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_cnt == IW'(FILT_CYCLES + 1)) begin
                    load_init = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cur != prev) begin
                    if (cur == fwd_next(prev)) begin
                        step_nxt = 1'b1;
                        fwd      = 1'b1;
                    end else if (prev == fwd_next(cur)) begin
                        step_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // prev takes the filters' in-flight values so an edge settling on the last INIT cycle is not seen as a transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt <= '0;
            prev     <= 2'b00;
            step_q   <= 1'b0;
            err_q    <= 1'b0;
            dir_q    <= 1'b0;
            ticks_q  <= 1'b0;
            div_cnt  <= '0;
        end else begin
            step_q <= step_nxt;
            err_q  <= err_nxt;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
            if (load_init) begin
                prev <= {a_nxt, b_nxt};
            end else if (state == ST_RUN) begin
                prev <= cur;
            end
            if (step_nxt) begin
                dir_q <= fwd;
                if (div_cnt == DW'(TICK_DIV - 1)) begin
                    div_cnt <= '0;
                    ticks_q <= ~ticks_q;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

`ifdef ENC_POS_COUNT_EN
    logic signed [POS_W-1:0] pos_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q <= '0;
        end else if (step_nxt) begin
            pos_q <= fwd ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
        end
    end

    assign bus.pos = pos_q;
`else
    assign bus.pos = '0;
`endif

    assign bus.ticks = ticks_q;
    assign bus.step  = step_q;
    assign bus.dir   = dir_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_enc_quad_frontend.sv
// tb/tb_enc_quad_frontend.sv - self-checking bench for enc_quad_frontend
module tb_enc_quad_frontend;
    localparam int FILT = 4;
    localparam int TDIV = 2;
    localparam int PW   = 4;
`ifdef ENC_POS_COUNT_EN
    localparam bit POS_EN = 1'b1;
`else
    localparam bit POS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    enc_quad_frontend_if #(.POS_W(PW)) bus ();

    enc_quad_frontend #(
        .FILT_CYCLES (FILT),
        .TICK_DIV    (TDIV),
        .POS_W       (PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mon_steps = 0;
    int mon_errs  = 0;

    always @(negedge clk) begin
        mon_steps += int'(bus.step);
        mon_errs  += int'(bus.err);
    end

    // Reference model: position along the Gray cycle decides the move
    logic [1:0] cur_ab;
    int         m_steps, m_errs, m_div_steps, m_pos;
    bit         m_dir;
    logic [1:0] seq [4];

    typedef struct {
        logic [1:0] ab;
        int         steps;
        int         errs;
        bit         dir;
        int         pos;
        bit         ticks;
    } vec_t;
    vec_t tab [8];

    function automatic int gidx(input logic [1:0] s);
        case (s)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int pos_now();
        logic [PW-1:0] p;
        p = bus.pos;
        return int'(p);
    endfunction

    task automatic model_update(input logic [1:0] s);
        int d;
        d = (gidx(s) - gidx(cur_ab) + 4) % 4;
        if (d == 1 || d == 3) begin
            m_steps++;
            m_div_steps++;
            m_dir = (d == 1);
            if (POS_EN) m_pos = (m_pos + ((d == 1) ? 1 : -1)) & ((1 << PW) - 1);
        end else if (d == 2) begin
            m_errs++;
        end
        cur_ab = s;
    endtask

    task automatic apply(input logic [1:0] s, input int hold);
        model_update(s);
        bus.enc_a = s[1];
        bus.enc_b = s[0];
        repeat (hold) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_steps"}, mon_steps, m_steps);
        check({tag, "_errs"}, mon_errs, m_errs);
        check({tag, "_dir"}, int'(bus.dir), int'(m_dir));
        check({tag, "_pos"}, pos_now(), m_pos);
        check({tag, "_ticks"}, int'(bus.ticks), (m_div_steps / TDIV) % 2);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ticks"}, int'(bus.ticks), 0);
        check({tag, "_step"}, int'(bus.step), 0);
        check({tag, "_dir"}, int'(bus.dir), 0);
        check({tag, "_err"}, int'(bus.err), 0);
        check({tag, "_pos"}, pos_now(), 0);
    endtask

    task automatic fwd_step(input int hold);
        apply(seq[(gidx(cur_ab) + 1) % 4], hold);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int quiet_bad;
        logic [1:0] s;
        seq = '{2'b00, 2'b10, 2'b11, 2'b01};
        tab[0] = '{2'b10, 1, 0, 1'b1, 1, 1'b0};
        tab[1] = '{2'b11, 2, 0, 1'b1, 2, 1'b1};
        tab[2] = '{2'b01, 3, 0, 1'b1, 3, 1'b1};
        tab[3] = '{2'b00, 4, 0, 1'b1, 4, 1'b0};
        tab[4] = '{2'b01, 5, 0, 1'b0, 3, 1'b0};
        tab[5] = '{2'b11, 6, 0, 1'b0, 2, 1'b1};
        tab[6] = '{2'b10, 7, 0, 1'b0, 1, 1'b1};
        tab[7] = '{2'b00, 8, 0, 1'b0, 0, 1'b0};
        cur_ab = 2'b00;
        m_steps = 0; m_errs = 0; m_div_steps = 0; m_pos = 0; m_dir = 1'b0;
        bus.enc_a = 1'b0;
        bus.enc_b = 1'b0;

        repeat (3) @(negedge clk);
        check_zero("in_reset");
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check_zero("after_init");

        for (int i = 0; i < 8; i++) begin
            apply(tab[i].ab, 20);
            check($sformatf("tab%0d_steps", i), mon_steps, tab[i].steps);
            check($sformatf("tab%0d_errs", i), mon_errs, tab[i].errs);
            check($sformatf("tab%0d_dir", i), int'(bus.dir), int'(tab[i].dir));
            check($sformatf("tab%0d_pos", i), pos_now(), POS_EN ? tab[i].pos : 0);
            check($sformatf("tab%0d_ticks", i), int'(bus.ticks), int'(tab[i].ticks));
        end

        bus.enc_a = 1'b1;
        repeat (3) @(negedge clk);
        bus.enc_a = 1'b0;
        repeat (20) @(negedge clk);
        check_state("glitch");

        model_update(2'b10);
        bus.enc_a = 1'b1;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.step && lat < 0) lat = k;
        end
        check("step_latency", lat, FILT + 3);
        @(negedge clk);
        repeat (10) @(negedge clk);
        check_state("latency");

        apply(2'b01, 20);
        check_state("both_toggle");
        apply(2'b11, 20);
        check_state("to_11");

        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        m_div_steps = 0; m_pos = 0; m_dir = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        quiet_bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.step || bus.err) quiet_bad++;
        end
        check("init_quiet", quiet_bad, 0);
        check_state("rst_settled");
        apply(2'b01, 20);
        check_state("post_rst");

        for (int k = 0; k < 6; k++) fwd_step(10);
        check_state("pre_wrap");
        fwd_step(10);
        check("wrap_pos", pos_now(), POS_EN ? 8 : 0);
        check_state("wrap");

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) < 2) begin
                s = cur_ab;
                if ($urandom_range(0, 1) == 1) s[1] = ~s[1];
                else s[0] = ~s[0];
                bus.enc_a = s[1];
                bus.enc_b = s[0];
                repeat ($urandom_range(1, 3)) @(negedge clk);
                bus.enc_a = cur_ab[1];
                bus.enc_b = cur_ab[0];
                repeat (10) @(negedge clk);
            end else begin
                s = 2'($urandom_range(0, 3));
                apply(s, $urandom_range(9, 14));
            end
            check_state($sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
